// File: rtl/sync_fifo_level_if.sv
// Write/read handshake bundle for sync_fifo_level.
// master: producer/consumer side (drives data_in, data_in_valid, data_out_ack).
// slave : FIFO side (drives full/almost_full, data_out, data_out_valid, almost_empty).
interface sync_fifo_level_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_full;
  logic                  data_in_almost_full;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ack;
  logic                  data_out_almost_empty;

  modport master (
    output data_in, data_in_valid, data_out_ack,
    input  data_in_full, data_in_almost_full, data_out, data_out_valid, data_out_almost_empty
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ack,
    output data_in_full, data_in_almost_full, data_out, data_out_valid, data_out_almost_empty
  );
endinterface

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with arbitrary depth, exact fill level, programmable
// almost-full/almost-empty flags, synchronous flush and sticky error flags.
// Ports:
//   clock_in, rst_out_n (async, active-low)
//   flush      : synchronous clear of contents (wins over read/write)
//   err_clear  : synchronous clear of overflow/underflow (a set in the same cycle wins)
//   bus        : slave side of sync_fifo_level_if (write and read handshakes)
//   fill_level : number of stored words, 0..DEPTH
//   overflow   : sticky, refused write seen
//   underflow  : sticky, ack without valid seen
// Build option SYNC_FIFO_OUTREG_EN: data_out comes from a prefetch register
// (2-cycle write-to-valid); otherwise data_out reads mem[rd_ptr] directly.
module sync_fifo_level #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned AFULL_LEVEL  = DEPTH - 2,
  parameter int unsigned AEMPTY_LEVEL = 2,
  parameter int unsigned COUNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                   clock_in,
  input  logic                   rst_out_n,
  input  logic                   flush,
  input  logic                   err_clear,
  sync_fifo_level_if.slave       bus,
  output logic [COUNT_WIDTH-1:0] fill_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0]   PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL   = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_AFULL  = COUNT_WIDTH'(AFULL_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] CNT_AEMPTY = COUNT_WIDTH'(AEMPTY_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [COUNT_WIDTH-1:0] count, count_nxt;
  logic                   full_q, afull_q, aempty_q, valid_q, valid_nxt;
  logic                   overflow_nxt, underflow_nxt;
  logic                   wr_acc, rd_acc, mem_rd;

  // Binary pointer wrap by compare so any DEPTH works.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign wr_acc = bus.data_in_valid && !full_q;
  assign rd_acc = bus.data_out_ack && valid_q;

`ifdef SYNC_FIFO_OUTREG_EN
  // Prefetch register: memory head moves into it when it is empty or being acked.
  // count covers memory plus register; mem_cnt covers memory only.
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COUNT_WIDTH-1:0] mem_cnt, mem_cnt_nxt;
  logic                   load;

  assign load   = (!valid_q || rd_acc) && (mem_cnt != '0);
  assign mem_rd = load;

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    valid_nxt   = valid_q;
    if (flush) begin
      mem_cnt_nxt = '0;
      valid_nxt   = 1'b0;
    end else begin
      case ({wr_acc, load})
        2'b10:   mem_cnt_nxt = mem_cnt + CNT_ONE;
        2'b01:   mem_cnt_nxt = mem_cnt - CNT_ONE;
        default: mem_cnt_nxt = mem_cnt;
      endcase
      valid_nxt = (valid_q && !rd_acc) || (mem_cnt != '0);
    end
  end

  always_ff @(posedge clock_in or negedge rst_out_n) begin
    if (!rst_out_n) mem_cnt <= '0;
    else            mem_cnt <= mem_cnt_nxt;
  end

  always_ff @(posedge clock_in) begin
    if (load && !flush) out_data <= mem[rd_ptr];
  end

  assign bus.data_out = out_data;
`else
  assign mem_rd       = rd_acc;
  assign valid_nxt    = (count_nxt != '0);
  assign bus.data_out = mem[rd_ptr];
`endif

  // Next pointers and occupancy; flush overrides any read/write this cycle.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (wr_acc) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (mem_rd) rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // Sticky errors: a set condition beats err_clear in the same cycle.
  always_comb begin
    overflow_nxt  = (bus.data_in_valid && full_q) || (overflow && !err_clear);
    underflow_nxt = (bus.data_out_ack && !valid_q) || (underflow && !err_clear);
  end

  // Storage has no reset; a flushed cycle writes nothing.
  always_ff @(posedge clock_in) begin
    if (wr_acc && !flush) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers, count and status flags, all derived from the next count.
  always_ff @(posedge clock_in or negedge rst_out_n) begin
    if (!rst_out_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      valid_q   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      full_q    <= (count_nxt == CNT_FULL);
      afull_q   <= (count_nxt >= CNT_AFULL);
      aempty_q  <= (count_nxt <= CNT_AEMPTY);
      valid_q   <= valid_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  assign bus.data_in_full          = full_q;
  assign bus.data_in_almost_full   = afull_q;
  assign bus.data_out_valid        = valid_q;
  assign bus.data_out_almost_empty = aempty_q;
  assign fill_level                = count;

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level: a DEPTH=16 instance (a) and a
// DEPTH=5, AFULL_LEVEL=3 instance (b), checked against a queue-based model.
module tb_sync_fifo_level;
  localparam int unsigned DW = 32;

  logic clock_in = 1'b0;
  logic rst_out_n;
  logic flush_a, err_clear_a, flush_b, err_clear_b;
  logic [4:0] fill_a;
  logic [2:0] fill_b;
  logic ovf_a, unf_a, ovf_b, unf_b;

  int checks = 0;
  int failures = 0;
  bit outreg_build;

  sync_fifo_level_if #(.DATA_WIDTH(DW)) a_if ();
  sync_fifo_level_if #(.DATA_WIDTH(DW)) b_if ();

  sync_fifo_level #(.DEPTH(16), .DATA_WIDTH(DW)) dut_a (
    .clock_in(clock_in), .rst_out_n(rst_out_n), .flush(flush_a), .err_clear(err_clear_a),
    .bus(a_if.slave), .fill_level(fill_a), .overflow(ovf_a), .underflow(unf_a)
  );

  sync_fifo_level #(.DEPTH(5), .DATA_WIDTH(DW), .AFULL_LEVEL(3), .AEMPTY_LEVEL(2)) dut_b (
    .clock_in(clock_in), .rst_out_n(rst_out_n), .flush(flush_b), .err_clear(err_clear_b),
    .bus(b_if.slave), .fill_level(fill_b), .overflow(ovf_b), .underflow(unf_b)
  );

  always #5 clock_in = ~clock_in;

  // Reference model: contents as a queue, visible-head flag, sticky flags.
  int unsigned m_depth [2] = '{16, 5};
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  bit m_ov [2];
  bit m_ovf [2];
  bit m_unf [2];

  task automatic model_clear();
    qa.delete();
    qb.delete();
    for (int id = 0; id < 2; id++) begin
      m_ov[id] = 1'b0; m_ovf[id] = 1'b0; m_unf[id] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int id = 0; id < 2; id++) begin
      logic [DW-1:0] q [$];
      logic [DW-1:0] d;
      bit v, ack, fl, ec, full, wr, rd, mem_nonempty;
      if (id == 0) begin
        q = qa; v = a_if.data_in_valid; ack = a_if.data_out_ack; d = a_if.data_in;
        fl = flush_a; ec = err_clear_a;
      end else begin
        q = qb; v = b_if.data_in_valid; ack = b_if.data_out_ack; d = b_if.data_in;
        fl = flush_b; ec = err_clear_b;
      end
      full = (q.size() == m_depth[id]);
      wr = v && !full;
      rd = ack && m_ov[id];
      m_ovf[id] = (v && full) || (m_ovf[id] && !ec);
      m_unf[id] = (ack && !m_ov[id]) || (m_unf[id] && !ec);
      // Words behind the visible head (only matters with the prefetch register).
      mem_nonempty = (q.size() > (m_ov[id] ? 1 : 0));
      if (fl) begin
        q.delete();
        m_ov[id] = 1'b0;
      end else begin
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(d);
        if (outreg_build) m_ov[id] = (m_ov[id] && !rd) || mem_nonempty;
        else              m_ov[id] = (q.size() != 0);
      end
      if (id == 0) qa = q; else qb = q;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic idle();
    a_if.data_in = '0; a_if.data_in_valid = 1'b0; a_if.data_out_ack = 1'b0;
    b_if.data_in = '0; b_if.data_in_valid = 1'b0; b_if.data_out_ack = 1'b0;
    flush_a = 1'b0; err_clear_a = 1'b0; flush_b = 1'b0; err_clear_b = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_out_n = 1'b0;
    #12;
    checks++;
    if ({a_if.data_in_full, a_if.data_in_almost_full, a_if.data_out_valid,
         a_if.data_out_almost_empty, ovf_a, unf_a} !== 6'b000100) begin
      failures++;
      $display("FAIL reset_flags_a got=%b want=000100", {a_if.data_in_full, a_if.data_in_almost_full,
               a_if.data_out_valid, a_if.data_out_almost_empty, ovf_a, unf_a});
    end
    checks++;
    if (fill_a !== 5'd0) begin failures++; $display("FAIL reset_fill_a got=%0d want=0", fill_a); end
    checks++;
    if ({b_if.data_in_full, b_if.data_in_almost_full, b_if.data_out_valid,
         b_if.data_out_almost_empty, ovf_b, unf_b, fill_b} !== 9'b000100_000) begin
      failures++;
      $display("FAIL reset_b got=%b want=000100000", {b_if.data_in_full, b_if.data_in_almost_full,
               b_if.data_out_valid, b_if.data_out_almost_empty, ovf_b, unf_b, fill_b});
    end
    @(negedge clock_in);
    rst_out_n = 1'b1;
    model_clear();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) begin
      a_if.data_in = DW'(i);
      a_if.data_in_valid = 1'b1;
      tick();
      checks++;
      if (fill_a !== 5'(i)) begin failures++; $display("FAIL fill_level_a got=%0d want=%0d", fill_a, i); end
      checks++;
      if (a_if.data_in_almost_full !== (i >= 14)) begin
        failures++; $display("FAIL almost_full_a at %0d got=%b", i, a_if.data_in_almost_full);
      end
      checks++;
      if (a_if.data_in_full !== (i == 16)) begin
        failures++; $display("FAIL full_a at %0d got=%b", i, a_if.data_in_full);
      end
      if (i <= 2) begin
        checks++;
        if (a_if.data_out_valid !== ((i == 2) || !outreg_build)) begin
          failures++;
          $display("FAIL write_to_valid_latency after write %0d got=%b outreg=%0d", i, a_if.data_out_valid, outreg_build);
        end
      end
    end
    a_if.data_in = 32'h11;
    tick();
    a_if.data_in_valid = 1'b0;
    checks++;
    if (ovf_a !== 1'b1) begin failures++; $display("FAIL overflow_a got=%b want=1", ovf_a); end
    checks++;
    if (fill_a !== 5'd16 || a_if.data_in_full !== 1'b1) begin
      failures++; $display("FAIL refused_write_a fill=%0d full=%b want 16/1", fill_a, a_if.data_in_full);
    end
  endtask

  task automatic test_drain();
    a_if.data_out_ack = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (a_if.data_out_valid !== 1'b1 || a_if.data_out !== DW'(i)) begin
        failures++;
        $display("FAIL drain_data_a valid=%b got=%h want=%h", a_if.data_out_valid, a_if.data_out, i);
      end
      tick();
      if (i == 1) begin
        checks++;
        if (a_if.data_in_full !== 1'b0) begin failures++; $display("FAIL full_deassert_a got=%b want=0", a_if.data_in_full); end
      end
    end
    a_if.data_out_ack = 1'b0;
    checks++;
    if (a_if.data_out_valid !== 1'b0 || fill_a !== 5'd0 || a_if.data_out_almost_empty !== 1'b1) begin
      failures++;
      $display("FAIL drained_a valid=%b fill=%0d aempty=%b want 0/0/1", a_if.data_out_valid, fill_a, a_if.data_out_almost_empty);
    end
  endtask

  task automatic test_underflow_clear();
    a_if.data_out_ack = 1'b1;
    tick();
    a_if.data_out_ack = 1'b0;
    checks++;
    if (unf_a !== 1'b1) begin failures++; $display("FAIL underflow_a got=%b want=1", unf_a); end
    err_clear_a = 1'b1;
    tick();
    checks++;
    if (ovf_a !== 1'b0 || unf_a !== 1'b0) begin
      failures++; $display("FAIL err_clear_a ovf=%b unf=%b want 0/0", ovf_a, unf_a);
    end
    a_if.data_out_ack = 1'b1;
    tick();
    a_if.data_out_ack = 1'b0;
    checks++;
    if (unf_a !== 1'b1) begin failures++; $display("FAIL set_beats_clear_a unf=%b want=1", unf_a); end
    tick();
    err_clear_a = 1'b0;
    checks++;
    if (unf_a !== 1'b0) begin failures++; $display("FAIL err_clear2_a unf=%b want=0", unf_a); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2; i++) begin
      b_if.data_in = $urandom;
      b_if.data_in_valid = 1'b1;
      tick();
    end
    b_if.data_out_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_if.data_in = $urandom;
      checks++;
      if (b_if.data_out_valid !== 1'b1 || b_if.data_out !== qb[0]) begin
        failures++;
        $display("FAIL wrap_data_b cyc=%0d valid=%b got=%h want=%h", i, b_if.data_out_valid, b_if.data_out, qb[0]);
      end
      tick();
      checks++;
      if (fill_b !== 3'd2) begin failures++; $display("FAIL wrap_fill_b cyc=%0d got=%0d want=2", i, fill_b); end
    end
    b_if.data_in_valid = 1'b0;
    for (int i = 0; i < 10 && qb.size() != 0; i++) begin
      b_if.data_out_ack = m_ov[1];
      if (m_ov[1]) begin
        checks++;
        if (b_if.data_out !== qb[0]) begin
          failures++; $display("FAIL wrap_drain_b got=%h want=%h", b_if.data_out, qb[0]);
        end
      end
      tick();
    end
    b_if.data_out_ack = 1'b0;
    checks++;
    if (fill_b !== 3'd0) begin failures++; $display("FAIL wrap_empty_b got=%0d want=0", fill_b); end
  endtask

  task automatic test_flags();
    b_if.data_in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      b_if.data_in = $urandom;
      tick();
      checks++;
      if ({b_if.data_in_almost_full, b_if.data_out_almost_empty, b_if.data_in_full} !==
          {(k >= 3), (k <= 2), (k == 5)} || fill_b !== 3'(k)) begin
        failures++;
        $display("FAIL flags_b fill=%0d want=%0d afull=%b aempty=%b full=%b", fill_b, k,
                 b_if.data_in_almost_full, b_if.data_out_almost_empty, b_if.data_in_full);
      end
    end
    tick();
    b_if.data_in_valid = 1'b0;
    checks++;
    if (ovf_b !== 1'b1 || fill_b !== 3'd5) begin
      failures++; $display("FAIL overflow_b ovf=%b fill=%0d want 1/5", ovf_b, fill_b);
    end
  endtask

  task automatic test_flush();
    a_if.data_out_ack = 1'b1;
    tick();
    a_if.data_out_ack = 1'b0;
    a_if.data_in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_if.data_in = $urandom;
      tick();
    end
    flush_a = 1'b1;
    a_if.data_in = 32'hDEAD_BEEF;
    a_if.data_out_ack = 1'b1;
    tick();
    flush_a = 1'b0;
    a_if.data_in_valid = 1'b0;
    a_if.data_out_ack = 1'b0;
    checks++;
    if (fill_a !== 5'd0 || {a_if.data_out_valid, a_if.data_out_almost_empty,
        a_if.data_in_almost_full, a_if.data_in_full} !== 4'b0100) begin
      failures++;
      $display("FAIL flush_a fill=%0d v/ae/af/f=%b want 0 and 0100", fill_a, {a_if.data_out_valid,
               a_if.data_out_almost_empty, a_if.data_in_almost_full, a_if.data_in_full});
    end
    checks++;
    if (unf_a !== 1'b1) begin failures++; $display("FAIL flush_sticky_a unf=%b want=1", unf_a); end
    a_if.data_in = 32'h0000_0ABC;
    a_if.data_in_valid = 1'b1;
    tick();
    a_if.data_in_valid = 1'b0;
    if (outreg_build) tick();
    checks++;
    if (a_if.data_out_valid !== 1'b1 || a_if.data_out !== 32'h0000_0ABC || fill_a !== 5'd1) begin
      failures++;
      $display("FAIL post_flush_a valid=%b data=%h fill=%0d want 1/00000abc/1", a_if.data_out_valid, a_if.data_out, fill_a);
    end
    a_if.data_out_ack = 1'b1;
    err_clear_a = 1'b1;
    tick();
    a_if.data_out_ack = 1'b0;
    err_clear_a = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      b_if.data_in = $urandom;
      b_if.data_in_valid = 1'($urandom_range(0, 1));
      b_if.data_out_ack = 1'($urandom_range(0, 1));
      flush_b = ($urandom_range(0, 31) == 0);
      err_clear_b = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (fill_b !== 3'(qb.size()) ||
          b_if.data_in_full !== (qb.size() == 5) ||
          b_if.data_in_almost_full !== (qb.size() >= 3) ||
          b_if.data_out_almost_empty !== (qb.size() <= 2) ||
          b_if.data_out_valid !== m_ov[1] || ovf_b !== m_ovf[1] || unf_b !== m_unf[1]) begin
        failures++;
        $display("FAIL random_status_b cyc=%0d fill=%0d/%0d full=%b af=%b ae=%b v=%b/%b ovf=%b/%b unf=%b/%b",
                 i, fill_b, qb.size(), b_if.data_in_full, b_if.data_in_almost_full, b_if.data_out_almost_empty,
                 b_if.data_out_valid, m_ov[1], ovf_b, m_ovf[1], unf_b, m_unf[1]);
      end
      if (m_ov[1]) begin
        checks++;
        if (b_if.data_out !== qb[0]) begin
          failures++; $display("FAIL random_data_b cyc=%0d got=%h want=%h", i, b_if.data_out, qb[0]);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    a_if.data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.data_in = $urandom;
      tick();
    end
    a_if.data_out_ack = 1'b1;
    a_if.data_in_valid = 1'b0;
    b_if.data_in_valid = 1'b1;
    tick();
    #1;
    rst_out_n = 1'b0;
    #1;
    checks++;
    if (fill_a !== 5'd0 || {a_if.data_in_full, a_if.data_in_almost_full, a_if.data_out_valid,
        a_if.data_out_almost_empty, ovf_a, unf_a} !== 6'b000100) begin
      failures++; $display("FAIL async_reset_a fill=%0d", fill_a);
    end
    checks++;
    if (fill_b !== 3'd0 || b_if.data_out_valid !== 1'b0 || b_if.data_out_almost_empty !== 1'b1) begin
      failures++; $display("FAIL async_reset_b fill=%0d valid=%b", fill_b, b_if.data_out_valid);
    end
    idle();
    @(negedge clock_in);
    rst_out_n = 1'b1;
    model_clear();
    a_if.data_in = 32'h5A5A_0001;
    a_if.data_in_valid = 1'b1;
    tick();
    a_if.data_in_valid = 1'b0;
    checks++;
    if (fill_a !== 5'd1) begin failures++; $display("FAIL first_write_after_reset got=%0d want=1", fill_a); end
  endtask

  initial begin
`ifdef SYNC_FIFO_OUTREG_EN
    outreg_build = 1'b1;
`else
    outreg_build = 1'b0;
`endif
    model_clear();
    test_reset();
    test_fill_overflow();
    test_drain();
    test_underflow_clear();
    test_wrap();
    test_flags();
    test_random();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
